// File: rtl/lsu_agu_arbiter_if.sv
// Request/response bundle between the load/store issue queues, the shared AGU
// arbiter and the LSU pipeline. The arbiter connects through the slave modport.
interface lsu_agu_arbiter_if #(
  parameter int unsigned XLEN             = 64,
  parameter int unsigned VIRTUAL_ADDR_LEN = 39,
  parameter int unsigned ROB_INDEX_WIDTH  = 6
);
  logic                        ld_valid_i;
  logic                        ld_ready_o;
  logic [XLEN-1:0]             ld_base_i;
  logic [XLEN-1:0]             ld_offset_i;
  logic [1:0]                  ld_size_i;
  logic [ROB_INDEX_WIDTH-1:0]  ld_rob_idx_i;

  logic                        st_valid_i;
  logic                        st_ready_o;
  logic [XLEN-1:0]             st_base_i;
  logic [XLEN-1:0]             st_offset_i;
  logic [1:0]                  st_size_i;
  logic [ROB_INDEX_WIDTH-1:0]  st_rob_idx_i;

  logic                        agu_valid_o;
  logic                        agu_ready_i;
  logic [VIRTUAL_ADDR_LEN-1:0] agu_addr_o;
  logic                        agu_is_store_o;
  logic [1:0]                  agu_size_o;
  logic [ROB_INDEX_WIDTH-1:0]  agu_rob_idx_o;
  logic                        agu_misalign_o;

  modport slave (
    input  ld_valid_i, ld_base_i, ld_offset_i, ld_size_i, ld_rob_idx_i,
    output ld_ready_o,
    input  st_valid_i, st_base_i, st_offset_i, st_size_i, st_rob_idx_i,
    output st_ready_o,
    input  agu_ready_i,
    output agu_valid_o, agu_addr_o, agu_is_store_o, agu_size_o, agu_rob_idx_o,
    output agu_misalign_o
  );

  modport master (
    output ld_valid_i, ld_base_i, ld_offset_i, ld_size_i, ld_rob_idx_i,
    input  ld_ready_o,
    output st_valid_i, st_base_i, st_offset_i, st_size_i, st_rob_idx_i,
    input  st_ready_o,
    output agu_ready_i,
    input  agu_valid_o, agu_addr_o, agu_is_store_o, agu_size_o, agu_rob_idx_o,
    input  agu_misalign_o
  );
endinterface

// File: rtl/lsu_agu_arbiter.sv
// Shares one AGU adder between load and store issue, with a registered valid/ready
// output stage. Define LSU_AGU_ARB_RR_EN for round-robin instead of load priority.
module lsu_agu_arbiter #(
  parameter int unsigned XLEN             = 64,
  parameter int unsigned VIRTUAL_ADDR_LEN = 39,
  parameter int unsigned ROB_INDEX_WIDTH  = 6,
  parameter int unsigned STARVE_LIMIT     = 4
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  flush_i,
  lsu_agu_arbiter_if.slave      io
);

  typedef enum logic {
    GNT_LOAD  = 1'b0,
    GNT_STORE = 1'b1
  } gnt_e;

  logic                        can_accept;
  logic                        grant_en;
  logic                        st_wins;
  logic                        ld_grant;
  logic                        st_grant;
  logic [VIRTUAL_ADDR_LEN-1:0] ld_addr;
  logic [VIRTUAL_ADDR_LEN-1:0] st_addr;
  logic [VIRTUAL_ADDR_LEN-1:0] sel_addr;
  logic [1:0]                  sel_size;
  logic                        sel_misalign;

  logic                        valid_q,    valid_d;
  logic [VIRTUAL_ADDR_LEN-1:0] addr_q,     addr_d;
  logic                        is_store_q, is_store_d;
  logic [1:0]                  size_q,     size_d;
  logic [ROB_INDEX_WIDTH-1:0]  rob_idx_q,  rob_idx_d;
  logic                        misalign_q, misalign_d;

`ifdef LSU_AGU_ARB_RR_EN
  gnt_e                        last_gnt_q, last_gnt_d;
`else
  localparam int unsigned CNT_W = (STARVE_LIMIT < 1) ? 1 : $clog2(STARVE_LIMIT + 1);
  localparam logic [CNT_W-1:0] STARVE_MAX = CNT_W'(STARVE_LIMIT);
  logic [CNT_W-1:0]            starve_cnt_q, starve_cnt_d;
`endif

  // Only the low VIRTUAL_ADDR_LEN bits of the operands reach the adder.
  logic unused_upper;
  assign unused_upper = ^{io.ld_base_i[XLEN-1:VIRTUAL_ADDR_LEN], io.ld_offset_i[XLEN-1:VIRTUAL_ADDR_LEN],
                          io.st_base_i[XLEN-1:VIRTUAL_ADDR_LEN], io.st_offset_i[XLEN-1:VIRTUAL_ADDR_LEN]};

  always_comb begin
    ld_addr = io.ld_base_i[VIRTUAL_ADDR_LEN-1:0] + io.ld_offset_i[VIRTUAL_ADDR_LEN-1:0];
    st_addr = io.st_base_i[VIRTUAL_ADDR_LEN-1:0] + io.st_offset_i[VIRTUAL_ADDR_LEN-1:0];

    can_accept = !valid_q || io.agu_ready_i;
    grant_en   = can_accept && !flush_i;
`ifdef LSU_AGU_ARB_RR_EN
    st_wins    = io.st_valid_i && (!io.ld_valid_i || (last_gnt_q == GNT_LOAD));
`else
    st_wins    = io.st_valid_i && (!io.ld_valid_i || (starve_cnt_q == STARVE_MAX));
`endif
    ld_grant   = grant_en && io.ld_valid_i && !st_wins;
    st_grant   = grant_en && st_wins;

    sel_addr = st_grant ? st_addr : ld_addr;
    sel_size = st_grant ? io.st_size_i : io.ld_size_i;
    case (sel_size)
      2'd0:    sel_misalign = 1'b0;
      2'd1:    sel_misalign = sel_addr[0];
      2'd2:    sel_misalign = |sel_addr[1:0];
      default: sel_misalign = |sel_addr[2:0];
    endcase
  end

  always_comb begin
    valid_d    = valid_q;
    addr_d     = addr_q;
    is_store_d = is_store_q;
    size_d     = size_q;
    rob_idx_d  = rob_idx_q;
    misalign_d = misalign_q;

    // Flush only clears valid; the payload keeps its last value.
    if (flush_i) begin
      valid_d = 1'b0;
    end else if (ld_grant || st_grant) begin
      valid_d    = 1'b1;
      addr_d     = sel_addr;
      is_store_d = st_grant;
      size_d     = sel_size;
      rob_idx_d  = st_grant ? io.st_rob_idx_i : io.ld_rob_idx_i;
      misalign_d = sel_misalign;
    end else if (io.agu_ready_i) begin
      valid_d = 1'b0;
    end
  end

`ifdef LSU_AGU_ARB_RR_EN
  always_comb begin
    last_gnt_d = last_gnt_q;
    if (st_grant) begin
      last_gnt_d = GNT_STORE;
    end else if (ld_grant) begin
      last_gnt_d = GNT_LOAD;
    end
  end
`else
  // Counts every cycle a valid store is passed over, including backpressure cycles.
  always_comb begin
    starve_cnt_d = '0;
    if (!flush_i && io.st_valid_i && !st_grant) begin
      starve_cnt_d = (starve_cnt_q == STARVE_MAX) ? STARVE_MAX : starve_cnt_q + CNT_W'(1);
    end
  end
`endif

  always_ff @(posedge clk) begin
    if (rst) begin
      valid_q    <= 1'b0;
      addr_q     <= '0;
      is_store_q <= 1'b0;
      size_q     <= '0;
      rob_idx_q  <= '0;
      misalign_q <= 1'b0;
`ifdef LSU_AGU_ARB_RR_EN
      last_gnt_q <= GNT_STORE;
`else
      starve_cnt_q <= '0;
`endif
    end else begin
      valid_q    <= valid_d;
      addr_q     <= addr_d;
      is_store_q <= is_store_d;
      size_q     <= size_d;
      rob_idx_q  <= rob_idx_d;
      misalign_q <= misalign_d;
`ifdef LSU_AGU_ARB_RR_EN
      last_gnt_q <= last_gnt_d;
`else
      starve_cnt_q <= starve_cnt_d;
`endif
    end
  end

  assign io.ld_ready_o     = ld_grant;
  assign io.st_ready_o     = st_grant;
  assign io.agu_valid_o    = valid_q;
  assign io.agu_addr_o     = addr_q;
  assign io.agu_is_store_o = is_store_q;
  assign io.agu_size_o     = size_q;
  assign io.agu_rob_idx_o  = rob_idx_q;
  assign io.agu_misalign_o = misalign_q;

endmodule

// File: tb/tb_lsu_agu_arbiter.sv
// Self-checking bench for lsu_agu_arbiter: directed scenarios then random traffic,
// all checked against a transaction-level reference model.
module tb_lsu_agu_arbiter;
  localparam int unsigned XLEN  = 64;
  localparam int unsigned VA    = 39;
  localparam int unsigned RW    = 6;
  localparam int unsigned LIMIT = 4;
  localparam longint unsigned VMASK = (64'd1 << VA) - 64'd1;
`ifdef LSU_AGU_ARB_RR_EN
  localparam int unsigned FIRST_ST = 2;
`else
  localparam int unsigned FIRST_ST = LIMIT + 1;
`endif

  logic clk = 1'b0;
  logic rst;
  logic flush;
  always #5 clk = ~clk;

  lsu_agu_arbiter_if #(.XLEN(XLEN), .VIRTUAL_ADDR_LEN(VA), .ROB_INDEX_WIDTH(RW)) bus ();

  lsu_agu_arbiter #(
    .XLEN(XLEN), .VIRTUAL_ADDR_LEN(VA), .ROB_INDEX_WIDTH(RW), .STARVE_LIMIT(LIMIT)
  ) dut (
    .clk(clk), .rst(rst), .flush_i(flush), .io(bus.slave)
  );

  int unsigned n_checks = 0;
  int unsigned n_fail   = 0;

  // Reference model: the held output transaction plus arbitration history.
  bit              m_valid, m_store, m_mis, m_last_store;
  longint unsigned m_addr;
  int unsigned     m_size, m_rob, m_cnt;
  bit              seen_st_ready;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
    end
  endtask

  function automatic longint unsigned gen_addr(input longint unsigned b, input longint unsigned o);
    return (b + o) & VMASK;
  endfunction

  function automatic bit is_mis(input longint unsigned a, input int unsigned sz);
    return (a % (64'd1 << sz)) != 0;
  endfunction

  // 0 = nobody, 1 = load, 2 = store
  function automatic int pick();
    if (flush) return 0;
    if (m_valid && !bus.agu_ready_i) return 0;
    if (bus.ld_valid_i && bus.st_valid_i) begin
`ifdef LSU_AGU_ARB_RR_EN
      return m_last_store ? 1 : 2;
`else
      return (m_cnt >= LIMIT) ? 2 : 1;
`endif
    end
    if (bus.ld_valid_i) return 1;
    if (bus.st_valid_i) return 2;
    return 0;
  endfunction

  task automatic cycle();
    int g;
    #3;
    g = pick();
    seen_st_ready = (bus.st_ready_o === 1'b1);
    if (!rst) begin
      check("ld_ready", 64'(bus.ld_ready_o), 64'(g == 1));
      check("st_ready", 64'(bus.st_ready_o), 64'(g == 2));
    end
    @(posedge clk);
    if (rst) begin
      m_valid = 0; m_addr = 0; m_store = 0; m_size = 0; m_rob = 0; m_mis = 0;
      m_cnt = 0; m_last_store = 1;
    end else if (flush) begin
      m_valid = 0; m_cnt = 0;
    end else begin
      if (g == 1) begin
        m_valid = 1; m_store = 0; m_last_store = 0;
        m_addr = gen_addr(bus.ld_base_i, bus.ld_offset_i);
        m_size = bus.ld_size_i; m_rob = bus.ld_rob_idx_i; m_mis = is_mis(m_addr, m_size);
      end else if (g == 2) begin
        m_valid = 1; m_store = 1; m_last_store = 1;
        m_addr = gen_addr(bus.st_base_i, bus.st_offset_i);
        m_size = bus.st_size_i; m_rob = bus.st_rob_idx_i; m_mis = is_mis(m_addr, m_size);
      end else if (bus.agu_ready_i) begin
        m_valid = 0;
      end
      if (bus.st_valid_i && g != 2) m_cnt = (m_cnt < LIMIT) ? m_cnt + 1 : LIMIT;
      else m_cnt = 0;
    end
    #1;
    check("agu_valid", 64'(bus.agu_valid_o), 64'(m_valid));
    if (m_valid || rst) begin
      check("agu_addr", 64'(bus.agu_addr_o), m_addr);
      check("agu_is_store", 64'(bus.agu_is_store_o), 64'(m_store));
      check("agu_size", 64'(bus.agu_size_o), 64'(m_size));
      check("agu_rob", 64'(bus.agu_rob_idx_o), 64'(m_rob));
      check("agu_misalign", 64'(bus.agu_misalign_o), 64'(m_mis));
    end
  endtask

  task automatic set_ld(input bit v, input longint unsigned b, input longint unsigned o,
                        input int unsigned sz, input int unsigned rob);
    bus.ld_valid_i = v; bus.ld_base_i = b; bus.ld_offset_i = o;
    bus.ld_size_i = 2'(sz); bus.ld_rob_idx_i = RW'(rob);
  endtask

  task automatic set_st(input bit v, input longint unsigned b, input longint unsigned o,
                        input int unsigned sz, input int unsigned rob);
    bus.st_valid_i = v; bus.st_base_i = b; bus.st_offset_i = o;
    bus.st_size_i = 2'(sz); bus.st_rob_idx_i = RW'(rob);
  endtask

  task automatic rand_operands(output longint unsigned b, output longint unsigned o);
    b = {$urandom(), $urandom()};
    if ($urandom_range(0, 1) == 0) b = b & ~64'h7;
    o = ($urandom_range(0, 1) == 0) ? 64'($urandom_range(0, 15)) : {$urandom(), $urandom()};
  endtask

  task automatic measure_first_store(input string tag);
    int unsigned first;
    first = 0;
    set_ld(1, 64'h3000, 0, 3, 11);
    set_st(1, 64'h4000, 0, 3, 12);
    bus.agu_ready_i = 1;
    for (int unsigned i = 1; i <= 10; i++) begin
      cycle();
      if (seen_st_ready && first == 0) first = i;
    end
    set_ld(0, 0, 0, 0, 0);
    set_st(0, 0, 0, 0, 0);
    check(tag, 64'(first), 64'(FIRST_ST));
  endtask

  initial begin
    longint unsigned b, o;
    m_valid = 0; m_addr = 0; m_store = 0; m_size = 0; m_rob = 0; m_mis = 0;
    m_cnt = 0; m_last_store = 1; seen_st_ready = 0;
    rst = 1; flush = 0;
    set_ld(0, 0, 0, 0, 0);
    set_st(0, 0, 0, 0, 0);
    bus.agu_ready_i = 1;
    cycle();
    cycle();
    rst = 0;

    // Load only, negative offset
    set_ld(1, 64'h1000, 64'hFFFF_FFFF_FFFF_FFF8, 3, 5);
    cycle();
    set_ld(0, 0, 0, 0, 0);
    check("load_addr", 64'(bus.agu_addr_o), 64'h0FF8);
    check("load_misalign", 64'(bus.agu_misalign_o), 64'd0);
    check("load_rob", 64'(bus.agu_rob_idx_o), 64'd5);
    check("load_is_store", 64'(bus.agu_is_store_o), 64'd0);

    // 39-bit wrap
    set_ld(1, 64'h7F_FFFF_FFFF, 64'd2, 0, 1);
    cycle();
    set_ld(0, 0, 0, 0, 0);
    check("wrap_addr", 64'(bus.agu_addr_o), 64'h1);
    check("wrap_misalign", 64'(bus.agu_misalign_o), 64'd0);

    // Misaligned word store
    set_st(1, 64'h2001, 64'd0, 2, 7);
    cycle();
    set_st(0, 0, 0, 0, 0);
    check("mis_flag", 64'(bus.agu_misalign_o), 64'd1);
    check("mis_is_store", 64'(bus.agu_is_store_o), 64'd1);

    measure_first_store("contention_first_st");
    cycle();

    // Backpressure with a pending store
    set_ld(1, 64'h100, 64'd8, 3, 9);
    cycle();
    set_ld(0, 0, 0, 0, 0);
    bus.agu_ready_i = 0;
    set_st(1, 64'h5000, 0, 3, 2);
    repeat (3) begin
      cycle();
      check("bp_addr", 64'(bus.agu_addr_o), 64'h108);
      check("bp_st_ready", 64'(seen_st_ready), 64'd0);
    end
    bus.agu_ready_i = 1;
    cycle();
    check("bp_release_st_ready", 64'(seen_st_ready), 64'd1);
    check("bp_release_addr", 64'(bus.agu_addr_o), 64'h5000);

    // Flush while held, with the starvation counter saturated
    bus.agu_ready_i = 0;
    set_ld(1, 64'h3000, 0, 3, 11);
    set_st(1, 64'h4000, 0, 3, 12);
    repeat (5) cycle();
    flush = 1;
    bus.agu_ready_i = 1;
    cycle();
    flush = 0;
    check("flush_st_ready", 64'(seen_st_ready), 64'd0);
    check("flush_valid", 64'(bus.agu_valid_o), 64'd0);
    measure_first_store("post_flush_first_st");

    // Random traffic
    for (int unsigned i = 0; i < 3000; i++) begin
      rand_operands(b, o);
      set_ld($urandom_range(0, 3) != 0, b, o, $urandom_range(0, 3), $urandom_range(0, 63));
      rand_operands(b, o);
      set_st($urandom_range(0, 3) != 0, b, o, $urandom_range(0, 3), $urandom_range(0, 63));
      bus.agu_ready_i = ($urandom_range(0, 9) < 7);
      flush = ($urandom_range(0, 19) == 0);
      rst   = ($urandom_range(0, 99) == 0);
      cycle();
    end

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end
endmodule

// File: doc/lsu_agu_arbiter.md
Name: lsu_agu_arbiter

Overview:
- Shares the single LSU address-generation adder between the load-issue and store-issue requesters.
- Picks one request per cycle and computes its virtual address (base + offset, truncated to VIRTUAL_ADDR_LEN).
- Checks natural alignment and registers the result into one output stage with a valid/ready handshake toward the LSU pipeline.
- Guarantees store forward progress under sustained load traffic; supports pipeline flush.

Parameters:
- XLEN, 64, operand width of base/offset.
- VIRTUAL_ADDR_LEN, 39, width of generated virtual address.
- ROB_INDEX_WIDTH, 6, width of ROB tag carried with each request.
- STARVE_LIMIT, 4, consecutive cycles a valid store may lose arbitration before it is forced to win.

Ports:
- clk  in  1  clock
- rst  in  1  synchronous active-high reset
- flush_i  in  1  pipeline flush; drops held and incoming requests
- ld_valid_i  in  1  load request valid
- ld_ready_o  out  1  load request accepted this cycle
- ld_base_i  in  XLEN  load base register value
- ld_offset_i  in  XLEN  load sign-extended immediate
- ld_size_i  in  2  0=B,1=H,2=W,3=D
- ld_rob_idx_i  in  ROB_INDEX_WIDTH  load ROB tag
- st_valid_i, st_ready_o, st_base_i, st_offset_i, st_size_i, st_rob_idx_i  same as ld_*, for the store requester
- agu_valid_o  out  1  output stage holds a request
- agu_ready_i  in  1  downstream accepts output
- agu_addr_o  out  VIRTUAL_ADDR_LEN  generated virtual address
- agu_is_store_o  out  1  1=store, 0=load
- agu_size_o  out  2  size of the held request
- agu_rob_idx_o  out  ROB_INDEX_WIDTH  ROB tag of the held request
- agu_misalign_o  out  1  address not naturally aligned for its size

Behaviour:
- Reset: agu_valid_o=0, agu_addr_o=0, agu_is_store_o=0, agu_size_o=0, agu_rob_idx_o=0, agu_misalign_o=0, starvation counter=0.
- Address: addr = base[VIRTUAL_ADDR_LEN-1:0] + offset[VIRTUAL_ADDR_LEN-1:0]; carry out is discarded (wraps modulo 2^VIRTUAL_ADDR_LEN).
- Misalign: size0 never; size1 addr[0]!=0; size2 addr[1:0]!=0; size3 addr[2:0]!=0. Misaligned requests are still passed through with the flag set.
- can_accept = !agu_valid_o || agu_ready_i.
- Grant is evaluated only when can_accept && !flush_i.
- Default priority: load wins when both are valid.
- Starvation counter:
  - increments (saturating at STARVE_LIMIT) each cycle st_valid_i=1 and the store is not granted;
  - clears when the store is granted or st_valid_i=0.
  - When counter==STARVE_LIMIT and st_valid_i=1, the store wins over the load.
- ld_ready_o / st_ready_o are combinational, one-hot or zero, and asserted only for the granted requester.
- Latency: 1 cycle from grant to agu_valid_o.
- Hold: if agu_valid_o && !agu_ready_i, all agu_* outputs stay stable and both ready outputs are 0.
- Back-to-back: output consumed and new grant in the same cycle → agu_valid_o stays 1 and the payload is replaced.
- Drain: output consumed with no new grant → agu_valid_o falls to 0 next cycle.
- flush_i=1: agu_valid_o clears next cycle, counter clears, both ready outputs are 0 that cycle. Payload registers may retain stale values. Flush has priority over agu_ready_i.
- rst asserted mid-transfer: same effect as flush, plus all payload outputs are zeroed.
- No request is ever duplicated or lost except by flush or reset.

Optional Feature:
- Macro LSU_AGU_ARB_RR_EN.
- Defined: strict round-robin between load and store using a 1-bit last-grant register (reset = store, so the first contended grant goes to load). The starvation counter is not implemented and STARVE_LIMIT is ignored.
- Undefined: load priority with the starvation counter, as above.

Test Plan:
- Load only: base=0x1000, offset=0xFFFF_FFFF_FFFF_FFF8, size=3, rob=5 → next cycle agu_valid_o=1, addr=0x0FF8, is_store=0, misalign=0, rob=5.
- Wrap: base=0x7F_FFFF_FFFF, offset=2, size=0 → addr=0x1 (39-bit wrap), misalign=0.
- Misalign: store base=0x2001, offset=0, size=2 → agu_misalign_o=1, is_store=1.
- Contention, STARVE_LIMIT=4, both valid every cycle, agu_ready_i=1 → grants L,L,L,L,S,L,L,L,L,S…; st_ready_o first asserted in cycle 5. With LSU_AGU_ARB_RR_EN: L,S,L,S…
- Backpressure: agu_ready_i=0 for 3 cycles with a held load → outputs stable, ld_ready_o=st_ready_o=0; on agu_ready_i=1 a pending store is granted the same cycle.
- Flush: held valid output with agu_ready_i=0, assert flush_i for 1 cycle → agu_valid_o=0 next cycle, no ready asserted during flush, counter=0.
